lsu_queue: RTL and testbench

- In-order load/store queue between decode/ALU and the L1 cache.
- Decode reserves entries in program order with LSU_OP_LOAD / LSU_OP_STORE.
- The ALU later fills addresses (LSU_OP_ADDR) and store data (LSU_OP_DATA) by tag, in any order.
- The queue issues the head entry to L1 as MEM_OP_LOAD / MEM_OP_STORE with one request outstanding, then retires it in order with a completion record that carries any MMU exception.

---
 rtl/lsu_queue_pkg.sv | 55 +++++
 rtl/lsu_queue.sv | 144 ++++++++++++++
 tb/tb_lsu_queue.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_queue_pkg.sv
// Shared types for the in-order load/store queue: the LSU/L1 op encodings,
// the MMU fault kinds, and the queue's entry, state and completion types.
package lsu_queue_pkg;

    typedef logic [63:0] data_t;

    typedef enum logic [2:0] {
        LSU_OP_NONE  = 3'd0,
        LSU_OP_LOAD  = 3'd1,
        LSU_OP_STORE = 3'd2,
        LSU_OP_ADDR  = 3'd3,
        LSU_OP_DATA  = 3'd4
    } lsu_op_e;

    typedef enum logic {
        MEM_OP_LOAD  = 1'b0,
        MEM_OP_STORE = 1'b1
    } mem_op_e;

    typedef enum logic [1:0] {
        MMU_UNMAPPED   = 2'd0,
        MMU_PROTECTED  = 2'd1,
        MMU_MISALIGNED = 2'd2,
        MMU_PAGE_FAULT = 2'd3
    } mmu_exception_e;

    typedef enum logic {
        S_ISSUE = 1'b0,
        S_WAIT  = 1'b1
    } lsq_state_e;

    typedef struct packed {
        logic  valid;
        logic  is_store;
        logic  addr_vld;
        logic  data_vld;
        data_t addr;
        data_t data;
    } lsq_entry_t;

    // The completion tag is held in a separate flop so this type stays
    // independent of the queue depth.
    typedef struct packed {
        logic           valid;
        logic           is_store;
        data_t          data;
        logic           exc_valid;
        mmu_exception_e exc;
    } lsq_cpl_t;

    function automatic logic lsq_issuable(input lsq_entry_t e);
        return e.valid && e.addr_vld && (!e.is_store || e.data_vld);
    endfunction

endpackage

// File: rtl/lsu_queue.sv
// In-order load/store queue: decode reserves entries, the ALU fills them by tag,
// and the head entry goes to L1 one request at a time before retiring in order.
module lsu_queue
    import lsu_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  lsu_op_e          alloc_op,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             upd_valid,
    input  lsu_op_e          upd_op,
    input  logic [TAG_W-1:0] upd_tag,
    input  data_t            upd_data,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output mem_op_e          mem_req_op,
    output logic [63:0]      mem_req_addr,
    output logic [63:0]      mem_req_data,
    output logic [TAG_W-1:0] mem_req_tag,
    input  logic             mem_resp_valid,
    input  logic [63:0]      mem_resp_data,
    input  logic             mem_resp_exc_valid,
    input  mmu_exception_e   mem_resp_exc,
    output logic             cpl_valid,
    output logic [TAG_W-1:0] cpl_tag,
    output logic             cpl_is_store,
    output logic [63:0]      cpl_data,
    output logic             cpl_exc_valid,
    output mmu_exception_e   cpl_exc,
    output lsq_state_e       dbg_state
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    lsq_entry_t       entries_q [DEPTH];
    lsq_entry_t       entries_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, cpl_tag_q, cpl_tag_d;
    logic [TAG_W:0]   count_q, count_d;
    lsq_state_e       state_q, state_d;
    lsq_cpl_t         cpl_q, cpl_d;
    lsq_entry_t       head_e;
    logic             do_alloc, do_retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= S_ISSUE;
            cpl_q     <= '{valid: 1'b0, is_store: 1'b0, data: '0, exc_valid: 1'b0, exc: MMU_UNMAPPED};
            cpl_tag_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            cpl_q     <= cpl_d;
            cpl_tag_q <= cpl_tag_d;
        end
    end

    // Handshakes: a transfer happens on a cycle where valid && ready; once
    // mem_req_valid is raised it and all mem_req_* stay stable until ready.
    assign head_e       = entries_q[head_q];
    assign alloc_ready  = (count_q != FULL_CNT);
    assign alloc_tag    = tail_q;
    assign mem_req_op   = head_e.is_store ? MEM_OP_STORE : MEM_OP_LOAD;
    assign mem_req_addr = head_e.addr;
    assign mem_req_data = head_e.is_store ? head_e.data : 64'd0;
    assign mem_req_tag  = head_q;
    assign do_alloc     = alloc_valid && alloc_ready &&
                          ((alloc_op == LSU_OP_LOAD) || (alloc_op == LSU_OP_STORE));

    assign cpl_valid     = cpl_q.valid;
    assign cpl_tag       = cpl_tag_q;
    assign cpl_is_store  = cpl_q.is_store;
    assign cpl_data      = cpl_q.data;
    assign cpl_exc_valid = cpl_q.exc_valid;
    assign cpl_exc       = cpl_q.exc;
    assign dbg_state     = state_q;

    always_comb begin
        entries_d     = entries_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        state_d       = state_q;
        cpl_d         = '{valid: 1'b0, is_store: 1'b0, data: '0, exc_valid: 1'b0, exc: MMU_UNMAPPED};
        cpl_tag_d     = '0;
        do_retire     = 1'b0;
        mem_req_valid = (state_q == S_ISSUE) && lsq_issuable(head_e);

        // Updates to the head are frozen while its request is waiting for ready.
        if (upd_valid && entries_q[upd_tag].valid &&
            !(mem_req_valid && !mem_req_ready && (upd_tag == head_q))) begin
            if (upd_op == LSU_OP_ADDR) begin
                entries_d[upd_tag].addr     = upd_data;
                entries_d[upd_tag].addr_vld = 1'b1;
            end else if ((upd_op == LSU_OP_DATA) && entries_q[upd_tag].is_store) begin
                entries_d[upd_tag].data     = upd_data;
                entries_d[upd_tag].data_vld = 1'b1;
            end
        end

        case (state_q)
            S_ISSUE: begin
                if (mem_req_valid && mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    do_retire       = 1'b1;
                    cpl_d.valid     = 1'b1;
                    cpl_d.is_store  = head_e.is_store;
                    cpl_d.data      = (head_e.is_store || mem_resp_exc_valid) ? 64'd0 : mem_resp_data;
                    cpl_d.exc_valid = mem_resp_exc_valid;
                    cpl_d.exc       = mem_resp_exc_valid ? mem_resp_exc : MMU_UNMAPPED;
                    cpl_tag_d       = head_q;
                    // Clearing the entry also discards a same-cycle update to it.
                    entries_d[head_q] = '0;
                    head_d          = head_q + TAG_W'(1);
                    state_d         = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase

        if (do_alloc) begin
            entries_d[tail_q] = '{valid: 1'b1, is_store: (alloc_op == LSU_OP_STORE),
                                  addr_vld: 1'b0, data_vld: 1'b0, addr: '0, data: '0};
            tail_d = tail_q + TAG_W'(1);
        end

        if (do_alloc && !do_retire)      count_d = count_q + (TAG_W+1)'(1);
        else if (!do_alloc && do_retire) count_d = count_q - (TAG_W+1)'(1);
    end

endmodule

// File: tb/tb_lsu_queue.sv
// Bench for lsu_queue: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against a program-order queue model.
module tb_lsu_queue;
    import lsu_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;
    localparam int CPL_W = TAG_W + 1 + 64 + 1 + 2;

    logic             clk, rst;
    logic             alloc_valid, alloc_ready;
    lsu_op_e          alloc_op;
    logic [TAG_W-1:0] alloc_tag;
    logic             upd_valid;
    lsu_op_e          upd_op;
    logic [TAG_W-1:0] upd_tag;
    data_t            upd_data;
    logic             mem_req_valid, mem_req_ready;
    mem_op_e          mem_req_op;
    logic [63:0]      mem_req_addr, mem_req_data;
    logic [TAG_W-1:0] mem_req_tag;
    logic             mem_resp_valid, mem_resp_exc_valid;
    logic [63:0]      mem_resp_data;
    mmu_exception_e   mem_resp_exc;
    logic             cpl_valid, cpl_is_store, cpl_exc_valid;
    logic [TAG_W-1:0] cpl_tag;
    logic [63:0]      cpl_data;
    mmu_exception_e   cpl_exc;
    lsq_state_e       dbg_state;

    lsu_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_op(alloc_op), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .upd_valid(upd_valid), .upd_op(upd_op), .upd_tag(upd_tag), .upd_data(upd_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_op(mem_req_op),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_exc_valid(mem_resp_exc_valid), .mem_resp_exc(mem_resp_exc),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_is_store(cpl_is_store), .cpl_data(cpl_data),
        .cpl_exc_valid(cpl_exc_valid), .cpl_exc(cpl_exc), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    int          order_q[$];          // live tags, oldest first
    bit          m_vld[DEPTH], m_st[DEPTH], m_av[DEPTH], m_dv[DEPTH];
    logic [63:0] m_addr[DEPTH], m_data[DEPTH];
    int          next_tag;
    bit          waiting;
    bit          cpl_due;
    logic [CPL_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        order_q.delete();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 0; m_st[i] = 0; m_av[i] = 0; m_dv[i] = 0;
            m_addr[i] = '0; m_data[i] = '0;
        end
        next_tag = 0;
        waiting  = 0;
        cpl_due  = 0;
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_op = LSU_OP_NONE;
        upd_valid = 0; upd_op = LSU_OP_NONE; upd_tag = '0; upd_data = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        mem_resp_exc_valid = 0; mem_resp_exc = MMU_UNMAPPED;
    endtask

    // Compare outputs against the model, advance the model over the coming edge
    // using the inputs currently driven, and move to the next falling edge.
    task automatic tick();
        int h;
        bit exp_rv, retire, accept, full;
        logic [CPL_W-1:0] e;
        logic [63:0] cd;
        h      = (order_q.size() > 0) ? order_q[0] : 0;
        exp_rv = !waiting && (order_q.size() > 0) && m_av[h] && (!m_st[h] || m_dv[h]);
        full   = (order_q.size() == DEPTH);

        chk("alloc_ready", 64'(alloc_ready), 64'(!full));
        if (!full) chk("alloc_tag", 64'(alloc_tag), 64'(next_tag));
        chk("mem_req_valid", 64'(mem_req_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("mem_req_op", 64'(mem_req_op), m_st[h] ? 64'(MEM_OP_STORE) : 64'(MEM_OP_LOAD));
            chk("mem_req_addr", mem_req_addr, m_addr[h]);
            chk("mem_req_data", mem_req_data, m_st[h] ? m_data[h] : 64'd0);
            chk("mem_req_tag", 64'(mem_req_tag), 64'(h));
        end
        chk("cpl_valid", 64'(cpl_valid), 64'(cpl_due));
        if (cpl_due && cpl_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cpl_tag", 64'(cpl_tag), 64'(e[CPL_W-1 -: TAG_W]));
            chk("cpl_is_store", 64'(cpl_is_store), 64'(e[67]));
            chk("cpl_data", cpl_data, e[66:3]);
            chk("cpl_exc_valid", 64'(cpl_exc_valid), 64'(e[2]));
            if (e[2]) chk("cpl_exc", 64'(cpl_exc), 64'(e[1:0]));
        end

        cpl_due = 0;
        if (rst) begin
            model_reset();
        end else begin
            retire = waiting && mem_resp_valid;
            accept = exp_rv && mem_req_ready;
            if (upd_valid && m_vld[upd_tag] && !(exp_rv && !mem_req_ready && upd_tag == h)
                && !(retire && upd_tag == h)) begin
                if (upd_op == LSU_OP_ADDR) begin
                    m_addr[upd_tag] = upd_data; m_av[upd_tag] = 1;
                end else if (upd_op == LSU_OP_DATA && m_st[upd_tag]) begin
                    m_data[upd_tag] = upd_data; m_dv[upd_tag] = 1;
                end
            end
            if (retire) begin
                cd = (m_st[h] || mem_resp_exc_valid) ? 64'd0 : mem_resp_data;
                exp_q.push_back({TAG_W'(h), m_st[h], cd, mem_resp_exc_valid,
                                 mem_resp_exc_valid ? 2'(mem_resp_exc) : 2'd0});
                cpl_due = 1;
                m_vld[h] = 0;
                void'(order_q.pop_front());
                waiting = 0;
            end
            if (accept) waiting = 1;
            if (alloc_valid && !full && (alloc_op == LSU_OP_LOAD || alloc_op == LSU_OP_STORE)) begin
                m_vld[next_tag] = 1; m_st[next_tag] = (alloc_op == LSU_OP_STORE);
                m_av[next_tag] = 0; m_dv[next_tag] = 0;
                order_q.push_back(next_tag);
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_upd(input lsu_op_e op, input int tag, input logic [63:0] d);
        upd_valid = 1; upd_op = op; upd_tag = TAG_W'(tag); upd_data = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_cpl_valid", 64'(cpl_valid), 64'd0);
        chk("rst_cpl_exc", 64'(cpl_exc), 64'(MMU_UNMAPPED));

        // single load round trip
        alloc_valid = 1; alloc_op = LSU_OP_LOAD; tick();
        idle(); drive_upd(LSU_OP_ADDR, 0, 64'h1000); tick();
        idle();
        chk("t1_req_valid", 64'(mem_req_valid), 64'd1);
        chk("t1_req_op", 64'(mem_req_op), 64'(MEM_OP_LOAD));
        chk("t1_req_addr", mem_req_addr, 64'h1000);
        chk("t1_req_data", mem_req_data, 64'd0);
        mem_req_ready = 1; tick();
        idle(); mem_resp_valid = 1; mem_resp_data = 64'hDEAD_BEEF; tick();
        idle();
        chk("t1_cpl_valid", 64'(cpl_valid), 64'd1);
        chk("t1_cpl_tag", 64'(cpl_tag), 64'd0);
        chk("t1_cpl_data", cpl_data, 64'hDEAD_BEEF);
        chk("t1_cpl_exc_valid", 64'(cpl_exc_valid), 64'd0);
        tick();

        // reset while waiting with three entries, then a stale response
        alloc_valid = 1; alloc_op = LSU_OP_LOAD; tick();
        drive_upd(LSU_OP_ADDR, 1, 64'h2000); tick();
        idle(); alloc_valid = 1; alloc_op = LSU_OP_LOAD; mem_req_ready = 1; tick();
        idle(); rst = 1; tick();
        rst = 0; mem_resp_valid = 1; mem_resp_data = 64'h1111;
        chk("rw_alloc_tag", 64'(alloc_tag), 64'd0);
        chk("rw_req_valid", 64'(mem_req_valid), 64'd0);
        tick();
        idle();
        chk("rw_cpl_valid", 64'(cpl_valid), 64'd0);
        chk("rw_alloc_ready", 64'(alloc_ready), 64'd1);
        tick();

        // store at tag0 blocks an earlier-ready load at tag1
        alloc_valid = 1; alloc_op = LSU_OP_STORE; tick();
        alloc_op = LSU_OP_LOAD; tick();
        idle(); drive_upd(LSU_OP_ADDR, 1, 64'h80); tick();
        idle(); chk("t2_load_blocked", 64'(mem_req_valid), 64'd0);
        drive_upd(LSU_OP_ADDR, 0, 64'h40); tick();
        drive_upd(LSU_OP_DATA, 0, 64'h55); tick();
        idle();
        chk("t2_st_op", 64'(mem_req_op), 64'(MEM_OP_STORE));
        chk("t2_st_addr", mem_req_addr, 64'h40);
        chk("t2_st_data", mem_req_data, 64'h55);
        chk("t2_st_tag", 64'(mem_req_tag), 64'd0);
        mem_req_ready = 1; tick();
        idle(); chk("t2_wait_noreq", 64'(mem_req_valid), 64'd0);
        mem_resp_valid = 1; tick();
        idle();
        chk("t2_cpl_store", 64'(cpl_is_store), 64'd1);
        chk("t2_ld_tag", 64'(mem_req_tag), 64'd1);
        chk("t2_ld_addr", mem_req_addr, 64'h80);
        mem_req_ready = 1; tick();
        idle(); mem_resp_valid = 1; mem_resp_data = 64'h77; tick();
        idle(); tick();

        // fill to full, hold alloc, retire once, wrap
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1; alloc_op = (i % 2) ? LSU_OP_STORE : LSU_OP_LOAD;
            chk("t3_fill_tag", 64'(alloc_tag), 64'(i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("t3_full", 64'(alloc_ready), 64'd0);
            tick();
        end
        drive_upd(LSU_OP_ADDR, 0, 64'h200); tick();
        upd_valid = 0; mem_req_ready = 1; tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 64'h9;
        chk("t3_full_on_retire", 64'(alloc_ready), 64'd0);
        tick();
        idle();
        chk("t3_ready_after", 64'(alloc_ready), 64'd1);
        chk("t3_wrap_tag", 64'(alloc_tag), 64'd0);
        tick();

        // request held under backpressure, then faulted store at tag1
        drive_upd(LSU_OP_ADDR, 1, 64'h300); tick();
        drive_upd(LSU_OP_DATA, 1, 64'h31); tick();
        idle();
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k == 0) drive_upd(LSU_OP_ADDR, 1, 64'h999);
            mem_req_ready = (k == 4);
            chk("t4_hold_valid", 64'(mem_req_valid), 64'd1);
            chk("t4_hold_addr", mem_req_addr, 64'h300);
            tick();
        end
        idle(); mem_resp_valid = 1; mem_resp_exc_valid = 1; mem_resp_exc = MMU_PROTECTED;
        mem_resp_data = 64'h1234; tick();
        idle();
        chk("t5_exc_valid", 64'(cpl_exc_valid), 64'd1);
        chk("t5_exc", 64'(cpl_exc), 64'(MMU_PROTECTED));
        chk("t5_data", cpl_data, 64'd0);
        chk("t5_tag", 64'(cpl_tag), 64'd1);
        drive_upd(LSU_OP_ADDR, 2, 64'h400); tick();
        idle();
        chk("t5_head_adv", 64'(mem_req_tag), 64'd2);
        tick();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            idle();
            rst = ($urandom_range(0, 499) == 0);
            alloc_valid = ($urandom_range(0, 1) == 0);
            alloc_op = lsu_op_e'($urandom_range(0, 4));
            upd_valid = ($urandom_range(0, 1) == 0);
            upd_op = ($urandom_range(0, 7) == 0) ? lsu_op_e'($urandom_range(0, 2))
                   : (($urandom_range(0, 1) == 0) ? LSU_OP_ADDR : LSU_OP_DATA);
            if (order_q.size() > 0 && $urandom_range(0, 3) != 0)
                upd_tag = TAG_W'(order_q[$urandom_range(0, order_q.size() - 1)]);
            else
                upd_tag = TAG_W'($urandom_range(0, DEPTH - 1));
            upd_data = {$urandom, $urandom};
            mem_req_ready = ($urandom_range(0, 3) != 0);
            mem_resp_valid = waiting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            mem_resp_data = {$urandom, $urandom};
            mem_resp_exc_valid = ($urandom_range(0, 5) == 0);
            mem_resp_exc = mmu_exception_e'($urandom_range(0, 3));
            tick();
        end
        idle(); rst = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
